// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor.
// A pattern history table (PHT) of 2-bit saturating counters is indexed by
// predict_pc XOR global history for prediction and by train_pc XOR
// train_history for training. The global history register (ghr) is shifted
// speculatively on every prediction request and is restored from the
// resolved branch's history on a mispredict.
// Optional build macro: GSHARE_STATS_EN adds a saturating 16-bit
// mispredict_count output.
module gshare_predictor #(
    parameter int          HIST_W   = 7,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              predict_valid,
    input  logic [HIST_W-1:0] predict_pc,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_history,
    input  logic              train_valid,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    input  logic [HIST_W-1:0] train_history,
    input  logic [HIST_W-1:0] train_pc
`ifdef GSHARE_STATS_EN
    ,
    output logic [15:0]       mispredict_count
`endif
);

    localparam int ENTRIES = 2 ** HIST_W;

    logic [HIST_W-1:0] r_ghr;
    logic [1:0]        r_pht [ENTRIES];

    logic [HIST_W-1:0] w_pidx;
    logic [HIST_W-1:0] w_tidx;
    logic [1:0]        w_cnt_cur;
    logic [1:0]        w_cnt_next;
    logic              w_recover;

    assign w_pidx    = predict_pc ^ r_ghr;
    assign w_tidx    = train_pc ^ train_history;
    assign w_recover = train_valid & train_mispredicted;

    // Prediction reads the pre-update counter; there is no bypass from training.
    always_comb begin
        predict_taken   = r_pht[w_pidx][1];
        predict_history = r_ghr;
    end

    // Saturating increment/decrement of the counter selected by training.
    always_comb begin
        w_cnt_cur  = r_pht[w_tidx];
        w_cnt_next = w_cnt_cur;
        if (train_taken) begin
            if (w_cnt_cur != 2'b11) begin
                w_cnt_next = w_cnt_cur + 2'd1;
            end
        end else begin
            if (w_cnt_cur != 2'b00) begin
                w_cnt_next = w_cnt_cur - 2'd1;
            end
        end
    end

    // PHT storage: all entries return to CNT_INIT on reset, one entry trains per edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CNT_INIT;
            end
        end else if (train_valid) begin
            r_pht[w_tidx] <= w_cnt_next;
        end
    end

    // Global history: mispredict recovery outranks the speculative shift.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_ghr <= '0;
        end else if (w_recover) begin
            r_ghr <= {train_history[HIST_W-2:0], train_taken};
        end else if (predict_valid) begin
            r_ghr <= {r_ghr[HIST_W-2:0], predict_taken};
        end
    end

`ifdef GSHARE_STATS_EN
    logic [15:0] r_mispredict_count;

    // Count mispredict pulses, holding at the maximum value.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_mispredict_count <= '0;
        end else if (w_recover && (r_mispredict_count != 16'hFFFF)) begin
            r_mispredict_count <= r_mispredict_count + 16'd1;
        end
    end

    assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor: directed vector table, hand-written reset
// sequence, then a random run against a small reference model.
module tb_gshare_predictor;

    localparam int HIST_W = 7;
    localparam int ENTRIES = 2 ** HIST_W;

    logic              clk;
    logic              areset_n;
    logic              predict_valid;
    logic [HIST_W-1:0] predict_pc;
    logic              predict_taken;
    logic [HIST_W-1:0] predict_history;
    logic              train_valid;
    logic              train_taken;
    logic              train_mispredicted;
    logic [HIST_W-1:0] train_history;
    logic [HIST_W-1:0] train_pc;
`ifdef GSHARE_STATS_EN
    logic [15:0]       mispredict_count;
`endif

    int checks = 0;
    int errors = 0;

    gshare_predictor #(.HIST_W(HIST_W), .CNT_INIT(2'b01)) dut (
        .clk                (clk),
        .areset_n           (areset_n),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_taken      (predict_taken),
        .predict_history    (predict_history),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc)
`ifdef GSHARE_STATS_EN
        ,
        .mispredict_count   (mispredict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              pv;
        logic [HIST_W-1:0] ppc;
        logic              tv;
        logic              tt;
        logic              tm;
        logic [HIST_W-1:0] th;
        logic [HIST_W-1:0] tpc;
        logic              exp_taken;
        logic [HIST_W-1:0] exp_hist;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic pv, logic [HIST_W-1:0] ppc, logic tv, logic tt,
                                logic tm, logic [HIST_W-1:0] th, logic [HIST_W-1:0] tpc,
                                logic et, logic [HIST_W-1:0] eh);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.tv = tv; v.tt = tt; v.tm = tm;
        v.th = th; v.tpc = tpc; v.exp_taken = et; v.exp_hist = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [HIST_W-1:0] ppc, input logic tv,
                         input logic tt, input logic tm, input logic [HIST_W-1:0] th,
                         input logic [HIST_W-1:0] tpc);
        predict_valid      = pv;
        predict_pc         = ppc;
        train_valid        = tv;
        train_taken        = tt;
        train_mispredicted = tm;
        train_history      = th;
        train_pc           = tpc;
    endtask

    // Reference model for the random phase
    logic [1:0]        m_pht [ENTRIES];
    logic [HIST_W-1:0] m_ghr;
    int                m_mis;

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        areset_n = 1'b1;
        #1 areset_n = 1'b0;

        // Saturation on PHT[3] with ghr=0
        vecs[0]  = mk(0, 7'd3, 1, 1, 0, 7'd0, 7'd3, 0, 7'd0);
        vecs[1]  = mk(0, 7'd3, 1, 1, 0, 7'd0, 7'd3, 1, 7'd0);
        vecs[2]  = mk(0, 7'd3, 1, 1, 0, 7'd0, 7'd3, 1, 7'd0);
        vecs[3]  = mk(0, 7'd3, 1, 1, 0, 7'd0, 7'd3, 1, 7'd0);
        vecs[4]  = mk(0, 7'd3, 1, 0, 0, 7'd0, 7'd3, 1, 7'd0);
        vecs[5]  = mk(0, 7'd3, 1, 0, 0, 7'd0, 7'd3, 1, 7'd0);
        vecs[6]  = mk(0, 7'd3, 1, 0, 0, 7'd0, 7'd3, 0, 7'd0);
        vecs[7]  = mk(0, 7'd3, 1, 0, 0, 7'd0, 7'd3, 0, 7'd0);
        vecs[8]  = mk(0, 7'd3, 1, 0, 0, 7'd0, 7'd3, 0, 7'd0);
        vecs[9]  = mk(0, 7'd3, 0, 0, 0, 7'd0, 7'd0, 0, 7'd0);
        vecs[10] = mk(0, 7'd3, 1, 1, 0, 7'd0, 7'd3, 0, 7'd0);
        vecs[11] = mk(0, 7'd3, 1, 1, 0, 7'd0, 7'd3, 0, 7'd0);
        vecs[12] = mk(0, 7'd3, 0, 0, 0, 7'd0, 7'd0, 1, 7'd0);
        // Same-index collision on PHT[9]: no bypass
        vecs[13] = mk(0, 7'd9, 1, 1, 0, 7'd0, 7'd9, 0, 7'd0);
        vecs[14] = mk(0, 7'd9, 0, 0, 0, 7'd0, 7'd0, 1, 7'd0);
        // Speculative shifts of NT predictions, then a taken one
        vecs[15] = mk(1, 7'd0, 0, 0, 0, 7'd0, 7'd0, 0, 7'd0);
        vecs[16] = mk(1, 7'd0, 0, 0, 0, 7'd0, 7'd0, 0, 7'd0);
        vecs[17] = mk(1, 7'd0, 0, 0, 0, 7'd0, 7'd0, 0, 7'd0);
        vecs[18] = mk(0, 7'd1, 1, 1, 0, 7'd0, 7'd1, 0, 7'd0);
        vecs[19] = mk(1, 7'd1, 0, 0, 0, 7'd0, 7'd0, 1, 7'd0);
        vecs[20] = mk(0, 7'd0, 0, 0, 0, 7'd0, 7'd0, 1, 7'd1);
        // Recovery to 0x2A, then recovery beating a speculative shift
        vecs[21] = mk(0, 7'd0, 1, 0, 1, 7'h15, 7'h15, 1, 7'd1);
        vecs[22] = mk(1, 7'h2A, 1, 1, 1, 7'h15, 7'h15, 0, 7'h2A);
        vecs[23] = mk(0, 7'h2A, 0, 0, 0, 7'd0, 7'd0, 1, 7'h2B);
        // Mispredict flag without train_valid must not touch history
        vecs[24] = mk(0, 7'h2A, 0, 0, 1, 7'd0, 7'h2A, 1, 7'h2B);
        vecs[25] = mk(0, 7'h2A, 0, 0, 0, 7'd0, 7'd0, 1, 7'h2B);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_taken", {15'd0, predict_taken}, 16'd0);
        chk("reset_hist", {9'd0, predict_history}, 16'd0);
        areset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].pv, vecs[i].ppc, vecs[i].tv, vecs[i].tt, vecs[i].tm,
                  vecs[i].th, vecs[i].tpc);
            #1;
            $display("vec %0d: pc=%0h taken=%0b hist=%0h", i, predict_pc, predict_taken,
                     predict_history);
            chk($sformatf("vec%0d_taken", i), {15'd0, predict_taken}, {15'd0, vecs[i].exp_taken});
            chk($sformatf("vec%0d_hist", i), {9'd0, predict_history}, {9'd0, vecs[i].exp_hist});
        end

        // Asynchronous reset mid-cycle after training PHT[5] to 3 (ghr is 0x2B)
        @(negedge clk);
        drive(1'b0, 7'h2E, 1'b1, 1'b1, 1'b0, 7'd0, 7'd5);
        @(negedge clk);
        drive(1'b0, 7'h2E, 1'b1, 1'b1, 1'b0, 7'd0, 7'd5);
        @(negedge clk);
        drive(1'b0, 7'h2E, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        #1;
        $display("pre-reset: pc=%0h taken=%0b hist=%0h", predict_pc, predict_taken, predict_history);
        chk("prereset_taken", {15'd0, predict_taken}, 16'd1);
        areset_n = 1'b0;
        #1;
        $display("in reset: taken=%0b hist=%0h", predict_taken, predict_history);
        chk("async_rst_taken", {15'd0, predict_taken}, 16'd0);
        chk("async_rst_hist", {9'd0, predict_history}, 16'd0);
        predict_pc = 7'd5;
        #1;
        chk("async_rst_pc5", {15'd0, predict_taken}, 16'd0);
        @(negedge clk);
        areset_n = 1'b1;
        drive(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        #1;
        $display("post-reset: pc=5 taken=%0b hist=%0h", predict_taken, predict_history);
        chk("post_rst_pc5", {15'd0, predict_taken}, 16'd0);
        chk("post_rst_hist", {9'd0, predict_history}, 16'd0);
        @(negedge clk);
        #1;
        chk("post_rst_shift_hist", {9'd0, predict_history}, 16'd0);

        // Fresh reset, then random traffic against the model
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        areset_n = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < ENTRIES; i++) m_pht[i] = 2'b01;
        m_ghr = '0;
        m_mis = 0;

        for (int c = 0; c < 1000; c++) begin
            logic              pv, tv, tt, tm, et;
            logic [HIST_W-1:0] ppc, th, tpc, pidx, tidx;
            @(negedge clk);
            pv  = 1'($urandom_range(1));
            ppc = HIST_W'($urandom);
            tv  = 1'($urandom_range(1));
            tt  = 1'($urandom_range(1));
            tm  = ($urandom_range(3) == 0);
            th  = HIST_W'($urandom);
            tpc = HIST_W'($urandom_range(15));
            predict_valid = pv;
            predict_pc    = ppc;
            train_valid   = tv;
            if (tv) begin
                train_taken = tt; train_mispredicted = tm;
                train_history = th; train_pc = tpc;
            end else begin
                train_taken = 1'bx; train_mispredicted = 1'bx;
                train_history = 'x; train_pc = 'x;
            end
            pidx = ppc ^ m_ghr;
            et   = m_pht[pidx][1];
            #1;
            chk($sformatf("rnd%0d_taken", c), {15'd0, predict_taken}, {15'd0, et});
            chk($sformatf("rnd%0d_hist", c), {9'd0, predict_history}, {9'd0, m_ghr});
            if (tv) begin
                tidx = tpc ^ th;
                if (tt && m_pht[tidx] != 2'b11) m_pht[tidx] = m_pht[tidx] + 2'd1;
                else if (!tt && m_pht[tidx] != 2'b00) m_pht[tidx] = m_pht[tidx] - 2'd1;
            end
            if (tv && tm) begin
                m_ghr = {th[HIST_W-2:0], tt};
                m_mis++;
            end else if (pv) begin
                m_ghr = {m_ghr[HIST_W-2:0], et};
            end
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        $display("random phase: %0d mispredict pulses", m_mis);
        chk("rnd_final_hist", {9'd0, predict_history}, {9'd0, m_ghr});
`ifdef GSHARE_STATS_EN
        chk("mispredict_count", mispredict_count, 16'(m_mis));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
